lifo_flex: RTL and testbench
============================

Name: lifo_flex

Overview:
- Parametrised successor to the single-port stack: synchronous LIFO with N-bit words and 2**depth entries.
- Adds occupancy count, programmable almost-full/almost-empty flags, a combinational top-of-stack peek, and a one-cycle pop-valid strobe.
- Defines simultaneous push+pop as replace-top, including when full.
- Used as a scratch/return stack in datapath and control blocks.

Parameters:
- N, 32, data word width in bits (>=1).
- depth, 3, log2 of entry count; stack holds 2**depth words (>=1).
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH; legal range 1..2**depth.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..2**depth-1.

Ports:
- clk  input  1  single clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  push request.
- rd_en  input  1  pop request.
- din  input  N  push data.
- err_clr  input  1  clears sticky error flags (Optional Feature).
- dout  output  N  registered popped word.
- dout_valid  output  1  high for exactly one cycle after each accepted pop.
- top  output  N  combinational peek: mem[count-1] when !empty, else 0.
- count  output  depth+1  current occupancy, 0..2**depth.
- full  output  1  count == 2**depth.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- overflow  output  1  sticky: push refused (Optional Feature).
- underflow  output  1  sticky: pop refused (Optional Feature).

Behaviour:
- Reset (synchronous, dominates wr_en/rd_en in the same cycle): count=0, dout=0, dout_valid=0, overflow=0, underflow=0. Memory array is not cleared. Flags follow from count: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0).
- Flags full, empty, almost_full, almost_empty and top are combinational from count and memory. No latency beyond the count register.
- Push only (wr_en & !rd_en):
  - !full: mem[count] <= din, count+1.
  - full: ignored; memory and count unchanged; overflow event.
- Pop only (rd_en & !wr_en):
  - !empty: dout <= mem[count-1], dout_valid=1 next cycle, count-1.
  - empty: ignored; dout holds its previous value; dout_valid=0; underflow event.
- Push+pop (wr_en & rd_en):
  - !empty, including full: dout <= old mem[count-1], dout_valid=1, mem[count-1] <= din, count unchanged. No overflow or underflow event.
  - empty: push proceeds (mem[0] <= din, count 0->1); pop refused; dout_valid=0; underflow event.
- dout holds its last popped value indefinitely. dout_valid deasserts in any cycle without an accepted pop.
- count width is depth+1, so count never wraps. Pointer arithmetic never exceeds 2**depth.
- top updates in the same cycle as count; after a replace-top it shows the new din.

Optional Feature:
- Macro: LIFO_FLEX_ERR_FLAGS_EN.
- Defined:
  - overflow/underflow are sticky registers, set on the corresponding refused-request event.
  - Cleared by reset, or by err_clr=1 at a clock edge.
  - If a set event and err_clr coincide, set wins (flag stays 1).
- Undefined:
  - overflow and underflow are tied to 0; err_clr is ignored.
  - Ports remain present so instantiations are identical in both builds.
- Refused requests are ignored identically in both builds.

Test Plan:
1. depth=3, AF_THRESH=6, AE_THRESH=1. Reset, then push 0x10,0x20,...,0x80 on consecutive cycles -> count 1..8; almost_empty drops once count reaches 2; almost_full rises when count=6; full=1 after 8th push; top=0x80.
2. Stack full, push 0xDEADBEEF with rd_en=0 -> count stays 8, top=0x80; overflow=1 (macro on) or 0 (macro off); err_clr pulse -> overflow=0.
3. Pop 8 consecutive cycles -> dout=0x80,0x70,...,0x10, each with dout_valid=1 the cycle after the pop; empty=1 after the last. 9th pop -> dout_valid=0, dout holds 0x10, underflow=1 (macro on).
4. From empty:
   - push 0xAAAA;
   - next cycle wr_en=rd_en=1 with din=0xBBBB -> dout=0xAAAA, dout_valid=1, count=1, top=0xBBBB;
   - pop -> dout=0xBBBB, empty=1.
5. Full stack, wr_en=rd_en=1 with din=0x1234 -> dout=0x80, count=8, full=1, top=0x1234, no overflow. Same on empty with din=0x55 -> count=1, top=0x55, dout_valid=0, underflow=1.
6. count=5 with wr_en=1, assert reset for one cycle -> next cycle count=0, empty=1, dout=0, dout_valid=0, error flags 0. Subsequent pop -> dout_valid=0.

Source files
------------

// File: rtl/lifo_flex.sv
// Synchronous LIFO with occupancy count, threshold flags, top-of-stack peek and pop strobe.
// Define LIFO_FLEX_ERR_FLAGS_EN to get sticky overflow/underflow flags cleared by err_clr.
module lifo_flex #(
    parameter int N         = 32,
    parameter int depth     = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [N-1:0]     din,
    input  logic             err_clr,
    output logic [N-1:0]     dout,
    output logic             dout_valid,
    output logic [N-1:0]     top,
    output logic [depth:0]   count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int             ENTRIES = 1 << depth;
    localparam logic [depth:0] CNT_MAX = (depth+1)'(ENTRIES);
    localparam logic [depth:0] AF_T    = (depth+1)'(AF_THRESH);
    localparam logic [depth:0] AE_T    = (depth+1)'(AE_THRESH);
    localparam logic [depth:0] ONE     = (depth+1)'(1);

    logic [N-1:0]   mem [ENTRIES];
    logic [depth:0] cnt_m1;
    logic           push_any;
    logic           pop_only;
    logic           pop_any;
    logic           repl;
    logic           ovf_evt;
    logic           udf_evt;

    assign cnt_m1 = count - ONE;

    assign full         = (count == CNT_MAX);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);
    assign top          = empty ? '0 : mem[cnt_m1[depth-1:0]];

    // Push+pop on an empty stack degrades to a plain push; on a non-empty stack it replaces the top.
    assign push_any = wr_en & ((!rd_en & !full) | (rd_en & empty));
    assign pop_only = rd_en & !wr_en & !empty;
    assign repl     = rd_en & wr_en & !empty;
    assign pop_any  = rd_en & !empty;
    assign ovf_evt  = wr_en & !rd_en & full;
    assign udf_evt  = rd_en & empty;

    // Storage carries no reset; writes are still suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push_any)
                mem[count[depth-1:0]] <= din;
            else if (repl)
                mem[cnt_m1[depth-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (push_any)
                count <= count + ONE;
            else if (pop_only)
                count <= cnt_m1;
            if (pop_any)
                dout <= mem[cnt_m1[depth-1:0]];
            dout_valid <= pop_any;
        end
    end

`ifdef LIFO_FLEX_ERR_FLAGS_EN
    // A new error event outranks a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (udf_evt)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_clr ^ ovf_evt ^ udf_evt;
    assign overflow   = 1'b0;
    assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_flex.sv
// Scoreboard bench for lifo_flex: stimulus queues expected popped words, a monitor checks them on dout_valid.
module tb_lifo_flex;

    localparam int N = 32;
    localparam int DEPTH = 3;
`ifdef LIFO_FLEX_ERR_FLAGS_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset, wr_en, rd_en, err_clr;
    logic [N-1:0]   din;
    logic [N-1:0]   dout, top;
    logic           dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [DEPTH:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [N-1:0] exp_q [$];

    lifo_flex #(.N(N), .depth(DEPTH), .AF_THRESH(6), .AE_THRESH(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .din(din),
        .err_clr(err_clr), .dout(dout), .dout_valid(dout_valid), .top(top),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] d);
        wr_en = 1'b1; rd_en = 1'b0; din = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic pop_exp(input logic [N-1:0] e);
        exp_q.push_back(e);
        wr_en = 1'b0; rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    // Monitor: every dout_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_valid: dout=0x%0h with no pop pending at %0t", dout, $time);
            end else begin
                chk("dout_scoreboard", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
        repeat (2) cycle();
        reset = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_dout", dout, 0);
        chk("rst_dv", 32'(dout_valid), 0);
        chk("rst_top", top, 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);

        // Fill 0x10..0x80
        for (int i = 1; i <= 8; i++) begin
            push(32'(i * 16));
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_ae", 32'(almost_empty), 32'(i <= 1));
            chk("fill_af", 32'(almost_full), 32'(i >= 6));
            chk("fill_full", 32'(full), 32'(i == 8));
            chk("fill_top", top, 32'(i * 16));
        end

        // Push into full stack
        push(32'hDEADBEEF);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_top", top, 32'h80);
        chk("ovf_flag", 32'(overflow), 32'(EXP_ERR));
        err_clr = 1'b1; cycle(); err_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // Drain in LIFO order
        for (int i = 8; i >= 1; i--) begin
            pop_exp(32'(i * 16));
            chk("drain_dv", 32'(dout_valid), 1);
            chk("drain_count", 32'(count), 32'(i - 1));
        end
        chk("drain_empty", 32'(empty), 1);
        rd_en = 1'b1; cycle(); rd_en = 1'b0;
        chk("udf_dv", 32'(dout_valid), 0);
        chk("udf_dout_hold", dout, 32'h10);
        chk("udf_flag", 32'(underflow), 32'(EXP_ERR));
        chk("udf_count", 32'(count), 0);
        err_clr = 1'b1; cycle(); err_clr = 1'b0;
        chk("udf_clr", 32'(underflow), 0);

        // Replace-top from one entry
        push(32'hAAAA);
        exp_q.push_back(32'hAAAA);
        wr_en = 1'b1; rd_en = 1'b1; din = 32'hBBBB;
        cycle();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("repl_dv", 32'(dout_valid), 1);
        chk("repl_dout", dout, 32'hAAAA);
        chk("repl_count", 32'(count), 1);
        chk("repl_top", top, 32'hBBBB);
        pop_exp(32'hBBBB);
        chk("repl_pop_empty", 32'(empty), 1);
        chk("repl_pop_dout", dout, 32'hBBBB);

        // Replace-top on a full stack
        for (int i = 1; i <= 8; i++) push(32'(i * 16));
        exp_q.push_back(32'h80);
        wr_en = 1'b1; rd_en = 1'b1; din = 32'h1234;
        cycle();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("frepl_dout", dout, 32'h80);
        chk("frepl_count", 32'(count), 8);
        chk("frepl_full", 32'(full), 1);
        chk("frepl_top", top, 32'h1234);
        chk("frepl_ovf", 32'(overflow), 0);
        pop_exp(32'h1234);
        for (int i = 7; i >= 1; i--) pop_exp(32'(i * 16));
        chk("frepl_drained", 32'(empty), 1);

        // Push+pop on empty: push wins, pop refused
        wr_en = 1'b1; rd_en = 1'b1; din = 32'h55;
        cycle();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("erepl_count", 32'(count), 1);
        chk("erepl_top", top, 32'h55);
        chk("erepl_dv", 32'(dout_valid), 0);
        chk("erepl_udf", 32'(underflow), 32'(EXP_ERR));

        // Reset dominates a push at count=5
        for (int i = 1; i <= 4; i++) push(32'(i));
        chk("pre_rst_count", 32'(count), 5);
        reset = 1'b1; wr_en = 1'b1; din = 32'h99;
        cycle();
        reset = 1'b0; wr_en = 1'b0;
        chk("rst2_count", 32'(count), 0);
        chk("rst2_empty", 32'(empty), 1);
        chk("rst2_dout", dout, 0);
        chk("rst2_dv", 32'(dout_valid), 0);
        chk("rst2_ovf", 32'(overflow), 0);
        chk("rst2_udf", 32'(underflow), 0);
        rd_en = 1'b1; cycle(); rd_en = 1'b0;
        chk("rst2_pop_dv", 32'(dout_valid), 0);

        cycle();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
